// File: rtl/mean_removal_pkg.sv
// Shared types and constants for the mean-removal sequencing controller.
package mean_removal_pkg;

  typedef enum logic [1:0] {
    DP_RST = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2
  } mrc_state_e;

  localparam int DP_RST_CYCLES = 2;
  localparam int M_DEFAULT     = 32;

  // Datapath needs M+1 idle cycles to clear its window memory; one spare.
  function automatic int clear_len(input int m);
    return m + 2;
  endfunction

  // Samples swallowed by the datapath before its first output.
  function automatic int warmup_len(input int m);
    return m + 3;
  endfunction

endpackage

// File: rtl/mrc_out_fifo.sv
// First-word fall-through output FIFO with synchronous flush and occupancy count.
module mrc_out_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic                     full, push, pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign pop     = rd_en && !empty;
  // A read in the same cycle frees the slot, so a full FIFO may still take a write.
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/mean_removal_ctrl.sv
// Sequencer around the running-mean-removal datapath: reset/clear phasing,
// warm-up tracking, and credit-gated conversion of its output to valid/ready.
module mean_removal_ctrl
  import mean_removal_pkg::*;
#(
  parameter int M            = M_DEFAULT,
  parameter int DW           = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLEAR_CYCLES = clear_len(M),
  parameter int WARMUP       = warmup_len(M)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          restart,
  output logic          dp_reset_n,
  output logic [DW-1:0] dp_data,
  output logic          dp_valid,
  input  logic [DW-1:0] dp_out_data,
  input  logic          dp_out_valid,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          primed,
  output logic          busy
);

  localparam int CNT_MAX = (CLEAR_CYCLES > DP_RST_CYCLES) ? CLEAR_CYCLES : DP_RST_CYCLES;
  localparam int KW      = $clog2(CNT_MAX);
  localparam int WW      = $clog2(WARMUP + 1);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int FW      = $clog2(FIFO_DEPTH) + 1;

  mrc_state_e    state, state_nxt;
  logic [KW-1:0] cnt, cnt_nxt;
  logic          dp_rst_q;
  logic [WW-1:0] warm_cnt;
  logic [CW-1:0] credits;
  logic          accept, take, m_hs, run, flush;
  logic          fifo_empty;
  logic [FW-1:0] fifo_count;

  assign run        = (state == RUN);
  assign busy       = !run;
  assign s_ready    = run && (credits != '0);
  assign accept     = s_valid && s_ready;
  assign primed     = (warm_cnt == WW'(WARMUP));
  assign take       = accept && primed;
  assign m_valid    = !fifo_empty;
  assign m_hs       = m_valid && m_ready;
  assign flush      = restart || !run;
  assign dp_reset_n = reset_n && dp_rst_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (restart) begin
      state_nxt = DP_RST;
      cnt_nxt   = '0;
    end else begin
      case (state)
        DP_RST:
          if (cnt == KW'(DP_RST_CYCLES - 1)) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + KW'(1);
        CLEAR:
          if (cnt == KW'(CLEAR_CYCLES - 1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else cnt_nxt = cnt + KW'(1);
        RUN:     ;
        default: begin
          state_nxt = DP_RST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DP_RST;
      cnt      <= '0;
      dp_rst_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      // Registered release: datapath reset is low exactly while in DP_RST.
      dp_rst_q <= (state_nxt != DP_RST);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dp_valid <= 1'b0;
      dp_data  <= '0;
    end else begin
      dp_valid <= accept && !restart;
      if (accept) dp_data <= s_data;
    end
  end

  // Warm-up accepts are free: the datapath emits nothing for them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
      credits  <= CW'(FIFO_DEPTH);
    end else if (flush) begin
      warm_cnt <= '0;
      credits  <= CW'(FIFO_DEPTH);
    end else begin
      if (accept && !primed) warm_cnt <= warm_cnt + WW'(1);
      case ({take, m_hs})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: ;
      endcase
    end
  end

  mrc_out_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (dp_out_valid && run),
    .wr_data (dp_out_data),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Credits bound in-flight samples to the FIFO depth, so this never fires.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(dp_out_valid && run && !restart && (fifo_count == FW'(FIFO_DEPTH)) && !m_ready));

endmodule

// File: tb/tb_mean_removal_ctrl.sv
// Directed bench for mean_removal_ctrl with a behavioural datapath and scoreboard.
module tb_mean_removal_ctrl;

  localparam int DW     = 32;
  localparam int M      = 32;
  localparam int WARMUP = M + 3;

  logic          clock = 1'b0;
  logic          reset_n, restart, s_valid, m_ready;
  logic [DW-1:0] s_data;
  logic          s_ready, dp_reset_n, dp_valid, m_valid, primed, busy;
  logic [DW-1:0] dp_data, m_data, dp_out_data;
  logic          dp_out_valid;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mean_removal_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .restart      (restart),
    .dp_reset_n   (dp_reset_n),
    .dp_data      (dp_data),
    .dp_valid     (dp_valid),
    .dp_out_data  (dp_out_data),
    .dp_out_valid (dp_out_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .primed       (primed),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x[n-4] minus the mean of the 32 most recent samples (w[31] is x[n]).
  function automatic logic [DW-1:0] mr(input longint w[$]);
    longint s = 0;
    foreach (w[i]) s += w[i];
    return DW'(w[27] - (s >>> 5));
  endfunction

  // Behavioural stand-in for the pipelined datapath: one cycle latency,
  // silent for the first WARMUP samples after its reset.
  longint dp_win[$];
  int     dp_cnt;
  always @(posedge clock or negedge dp_reset_n) begin
    if (!dp_reset_n) begin
      dp_out_valid <= 1'b0;
      dp_out_data  <= '0;
      dp_cnt       <= 0;
      dp_win.delete();
    end else if (dp_valid) begin
      dp_win.push_back(longint'($signed(dp_data)));
      if (dp_win.size() > 32) void'(dp_win.pop_front());
      dp_cnt       <= dp_cnt + 1;
      dp_out_valid <= (dp_cnt >= WARMUP);
      dp_out_data  <= (dp_cnt >= WARMUP) ? mr(dp_win) : '0;
    end else begin
      dp_out_valid <= 1'b0;
    end
  end

  // Scoreboard: expected outputs pushed on accept, popped on m handshake.
  logic [DW-1:0] exp_q[$];
  longint        sb_win[$];
  int            sb_acc = 0;
  always @(negedge clock) begin
    if (!reset_n || restart) begin
      exp_q.delete();
      sb_win.delete();
      sb_acc = 0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_m_valid", m_valid, 0);
        else chk("m_data", m_data, exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        sb_win.push_back(longint'($signed(s_data)));
        if (sb_win.size() > 32) void'(sb_win.pop_front());
        sb_acc++;
        if (sb_acc > WARMUP) exp_q.push_back(mr(sb_win));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    step();
    chk(tag, exp_q.size(), 0);
    chk({tag, "_m_valid"}, m_valid, 0);
  endtask

  initial begin
    int n, v, cyc;
    logic acc;
    reset_n = 1'b0; restart = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dp_reset_n", dp_reset_n, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_data", dp_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_primed", primed, 0);
    chk("rst_busy", busy, 1);
    repeat (2) step();

    // Release and count the DP_RST + CLEAR phases.
    @(negedge clock);
    reset_n = 1'b1; s_valid = 1'b1; s_data = DW'(100); m_ready = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      chk("clr_s_ready", s_ready, 0);
      chk("clr_dp_valid", dp_valid, 0);
      chk("clr_busy", busy, 1);
      if (k <= 2) chk("rel_dp_reset_n", dp_reset_n, (k >= 2));
    end
    step();
    chk("run_s_ready", s_ready, 1);
    chk("run_busy", busy, 0);

    // Constant stream: silent warm-up, then all-zero outputs.
    for (int i = 0; i < WARMUP; i++) begin
      chk("warm_primed", primed, 0);
      chk("warm_m_valid", m_valid, 0);
      step();
    end
    chk("primed_after_35", primed, 1);
    for (int i = 0; i < 12; i++) begin
      if (m_valid) chk("const_zero", m_data, 0);
      step();
    end
    drain("const_drain");

    // Backpressure: only FIFO_DEPTH accepts fit.
    s_valid = 1'b1; m_ready = 1'b0; n = 0;
    repeat (12) begin
      s_data = DW'(500 + n);
      if (s_ready) n++;
      step();
    end
    chk("bp_accepts", n, 4);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    drain("bp_drain");

    // Restart with 3 entries queued.
    s_valid = 1'b1; m_ready = 1'b0; n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      s_data = DW'(n * 7 - 3);
      if (s_ready) n++;
      step();
    end
    s_valid = 1'b0;
    repeat (4) step();
    chk("pre_restart_m_valid", m_valid, 1);
    restart = 1'b1;
    step();
    restart = 1'b0; s_valid = 1'b1;
    chk("rs_m_valid", m_valid, 0);
    chk("rs_s_ready", s_ready, 0);
    chk("rs_dp_reset_n_1", dp_reset_n, 0);
    chk("rs_primed", primed, 0);
    chk("rs_busy", busy, 1);
    step();
    chk("rs_dp_reset_n_2", dp_reset_n, 0);
    step();
    chk("rs_dp_reset_n_3", dp_reset_n, 1);
    for (int i = 0; i < 34; i++) begin
      chk("rs_clr_s_ready", s_ready, 0);
      chk("rs_clr_dp_valid", dp_valid, 0);
      step();
    end
    chk("rs_run_s_ready", s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < WARMUP; i++) begin
      s_data = DW'(i * 3);
      chk("rs_warm_primed", primed, 0);
      step();
    end
    chk("rs_primed_again", primed, 1);

    // Signed ramp with random source gaps and sink stalls.
    v = -1000; cyc = 0;
    while (v <= 1000 && cyc < 20000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      s_data  = v;
      acc     = s_valid && s_ready;
      step();
      cyc++;
      if (acc) v++;
    end
    chk("ramp_complete", v, 1001);
    drain("ramp_drain");

    // Asynchronous reset mid-stream.
    s_valid = 1'b1; m_ready = 1'b1; s_data = DW'(7);
    repeat (40) step();
    #1 reset_n = 1'b0;
    #1;
    chk("ares_s_ready", s_ready, 0);
    chk("ares_dp_reset_n", dp_reset_n, 0);
    chk("ares_dp_valid", dp_valid, 0);
    chk("ares_dp_data", dp_data, 0);
    chk("ares_m_valid", m_valid, 0);
    chk("ares_m_data", m_data, 0);
    chk("ares_primed", primed, 0);
    chk("ares_busy", busy, 1);
    s_valid = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mean_removal_ctrl.md
# mean_removal_ctrl

Sequencing controller wrapped around the pipelined running-mean-removal datapath (`remove_mean_value_pipelined`). It holds the datapath reset and clear phases, feeds it from a valid/ready source, and tracks the M+3 warm-up samples that produce no output. It also converts the datapath's no-backpressure output into a valid/ready stream through a small output FIFO with credit-based input gating. It sits between the ADC/decimator stream and downstream processing, and exposes restart and status.

## Interface
- `M`, 32: averaging window; must equal the datapath's window (its `>>5` fixes 32).
- `DW`, 32: sample width, signed.
- `FIFO_DEPTH`, 4: output FIFO entries, power of 2, ≥2.
- `CLEAR_CYCLES`, M+2: idle cycles after datapath reset release before the first `dp_valid`.
- `WARMUP`, M+3: accepted samples after clear that produce no datapath output.

Ports:
- `clock`, in, 1: single clock, all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `s_data`, in, DW: input sample.
- `s_valid`, in, 1: input valid.
- `s_ready`, out, 1: input ready.
- `restart`, in, 1: single-cycle pulse. Flush and re-initialise the datapath.
- `dp_reset_n`, out, 1: drives the datapath `reset_n`.
- `dp_data`, out, DW: drives the datapath `data_in`.
- `dp_valid`, out, 1: drives the datapath `data_in_valid`.
- `dp_out_data`, in, DW: datapath `data_out`.
- `dp_out_valid`, in, 1: datapath `data_out_valid`.
- `m_data`, out, DW: output sample.
- `m_valid`, out, 1: output valid.
- `m_ready`, in, 1: output ready.
- `primed`, out, 1: warm-up complete, outputs now flowing.
- `busy`, out, 1: high in any state other than RUN.

## Operation
- States are DP_RST, CLEAR and RUN.
  - `reset_n` low forces DP_RST.
  - DP_RST lasts 2 cycles, then goes to CLEAR.
  - CLEAR counts CLEAR_CYCLES, then goes to RUN.
  - `restart` in any state goes to DP_RST next cycle; a restart pulse during DP_RST restarts its 2-cycle count.
- `dp_reset_n` is `reset_n` AND a register that is low in DP_RST (asynchronous assertion, registered release).
- `dp_valid` is 0 in DP_RST and CLEAR. This guarantees the datapath's memory-clear loop completes (it needs M+1 idle cycles).
- Handshakes: a transfer occurs when valid and ready are both high. `s_ready` = (state==RUN) && (credits > 0).
- Accept at edge t registers `dp_data` = `s_data` and `dp_valid` = 1 for the cycle after t. `dp_valid` is 0 in every cycle without a preceding accept.
- Warm-up:
  - `warm_cnt` counts accepts, saturating at WARMUP.
  - An accept while `warm_cnt` < WARMUP does not consume a credit.
  - `primed` = (`warm_cnt` == WARMUP).
- Credits:
  - Reset to FIFO_DEPTH on entering RUN.
  - A post-warm-up accept decrements by 1; an `m` handshake increments by 1; both in the same cycle net to 0.
  - Credits never exceed FIFO_DEPTH and never go below 0, so the FIFO cannot overflow.
- FIFO:
  - Written when `dp_out_valid`=1 and state==RUN.
  - `m_valid` = FIFO not empty, `m_data` = head entry (first-word fall-through).
  - Simultaneous write and read while full, or while empty, is legal.
- `dp_out_valid` while FIFO is full is a design error. Flag it with an assertion; nothing is written.
- Restart clears the FIFO, credits and `warm_cnt`, and discards pending data. `dp_out_valid` outside RUN is ignored.

## Timing
- Reset values: `s_ready`=0, `dp_reset_n`=0, `dp_valid`=0, `dp_data`=0, `m_valid`=0, `m_data`=0, `primed`=0, `busy`=1.
- After `reset_n` rises, `s_ready` first rises 2 + CLEAR_CYCLES cycles later (36 at defaults).
- Accept to `dp_valid`: 1 cycle. `dp_valid` to `dp_out_valid`: 1 cycle (datapath). `dp_out_valid` to `m_valid`: 1 cycle.
- Each post-warm-up accept yields exactly one output, corresponding to the sample accepted 4 accepts earlier.
- With `m_ready`=1 and `s_valid`=1 continuously, throughput is 1 sample/cycle with no bubbles.
- `restart` at edge t:
  - `s_ready` and `m_valid` are 0 from t+1.
  - `dp_reset_n` is low for cycles t+1 and t+2.

## Structure
- Package `mean_removal_pkg`: state enum (DP_RST, CLEAR, RUN), the DP_RST length constant (2), and the default M/WARMUP derivation.
- Sub-module `mrc_out_fifo`: parameterised synchronous FIFO (DW, FIFO_DEPTH, count output, flush input).
- The datapath is instantiated outside this block, alongside it, in the integrating top.

## Test plan
- Release reset, `s_valid`=1: `s_ready`=0 and `dp_valid`=0 for 36 cycles. The first accept occurs at cycle 36 and `busy` falls then.
- Constant 100 stream, `m_ready`=1: no `m_valid` for the first 35 accepts. `primed` rises after accept 35, and every output is 0.
- After priming, hold `m_ready`=0: exactly 4 more accepts, then `s_ready`=0 with FIFO full. Releasing gives a bit-exact sequence with no loss or duplication.
- With FIFO holding 3 entries, pulse `restart`:
  - `m_valid`=0 next cycle; `dp_reset_n` low for 2 cycles.
  - Full 36-cycle clear and 35-sample warm-up again.
- Assert `reset_n` low mid-stream, asynchronously: all outputs take their reset values before the next clock edge.
- Signed ramp −1000..+1000 with random `s_valid` gaps and random `m_ready`: outputs match a model of `x[n-4] − (sum of last 32 samples >>> 5)`.
